// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall / redirect flush controller for the non-forwarding 5-stage pipeline.
// Latency: outputs are combinational from the ID instruction and a 3-entry EX/MEM/WB dest scoreboard.
// Backpressure: a RAW stall holds PC and IF/ID and bubbles ID/EX; an EX redirect overrides the stall.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   id_inst_i            instruction in ID (RV32I encoding)
//   br_taken_i           taken branch / JAL / JALR resolved in EX
//   pc_en_o, ifid_en_o   PC and IF/ID load enables (low while stalling)
//   ifid_flush_o         IF/ID loads a NOP (redirect)
//   idex_flush_o         ID/EX loads a bubble (stall or redirect)
//   stall_o              RAW stall active this cycle
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o (32-bit, wrapping)
// counting stall cycles and redirect cycles.
module hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] id_inst_i,
  input  logic                  br_taken_i,
  output logic                  pc_en_o,
  output logic                  ifid_en_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_entry_t;

  sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;

  logic [4:0] opc, rd, rs1, rs2;
  logic       uses_rs1, uses_rs2, writes_rd;
  logic       hit_rs1, hit_rs2;
  logic       stall, issue;

  // Fields not needed for hazard detection (funct3/funct7/imm high bits, opcode[1:0]).
  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst_i[DATA_WIDTH-1:25], id_inst_i[14:12], id_inst_i[1:0]};

  assign opc = id_inst_i[6:2];
  assign rd  = id_inst_i[11:7];
  assign rs1 = id_inst_i[19:15];
  assign rs2 = id_inst_i[24:20];

  function automatic logic sb_hit(input logic [4:0] r, input sb_entry_t e);
    return e.vld && (e.rd == r);
  endfunction

  always_comb begin
    uses_rs1  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    uses_rs2  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    writes_rd = !((opc == OPC_BRANCH) || (opc == OPC_STORE)) && (rd != 5'd0);

    // With WB bypass the regfile writes in the first half-cycle, so the WB slot is safe to read.
    hit_rs1 = (rs1 != 5'd0) &&
              (sb_hit(rs1, sb_ex_q) || sb_hit(rs1, sb_mem_q) ||
               (!WB_BYPASS && sb_hit(rs1, sb_wb_q)));
    hit_rs2 = (rs2 != 5'd0) &&
              (sb_hit(rs2, sb_ex_q) || sb_hit(rs2, sb_mem_q) ||
               (!WB_BYPASS && sb_hit(rs2, sb_wb_q)));

    // A redirect kills the instruction in ID, so it cannot stall.
    stall = !br_taken_i && ((uses_rs1 && hit_rs1) || (uses_rs2 && hit_rs2));
    issue = !stall && !br_taken_i;
  end

  assign stall_o      = stall;
  assign pc_en_o      = !stall;
  assign ifid_en_o    = !stall;
  assign idex_flush_o = stall | br_taken_i;
  assign ifid_flush_o = br_taken_i;

  // Reset branch loads constants only, so an undriven ID instruction during reset
  // cannot leak into the scoreboard.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
    end else begin
      sb_wb_q  <= sb_mem_q;
      sb_mem_q <= sb_ex_q;
      sb_ex_q  <= issue ? sb_entry_t'{vld: writes_rd, rd: rd} : sb_entry_t'('0);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall)      stall_cnt_o <= stall_cnt_o + 32'd1;
      if (br_taken_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] ADDI5  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] ADD6   = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] ADDI0  = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] ADD600 = 32'h0000_0333; // add  x6,x0,x0
  localparam logic [31:0] SW52   = 32'h0051_2023; // sw   x5,0(x2)
  localparam logic [31:0] LW75   = 32'h0002_A383; // lw   x7,0(x5)
  localparam logic [31:0] ADDI6  = 32'h0010_0313; // addi x6,x0,1
  localparam logic [31:0] BEQ56  = 32'h0062_8063; // beq  x5,x6,0

  // expected = {stall_o, pc_en_o, ifid_flush_o, idex_flush_o}
  localparam logic [3:0] RUN = 4'b0100;
  localparam logic [3:0] STL = 4'b1001;
  localparam logic [3:0] BRF = 4'b0111;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [31:0] inst;
    logic        br;
    bit          chk;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 'x;
  logic        br = 1'b0;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, stall;
  int          total = 0;
  int          bad = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.DATA_WIDTH(32), .WB_BYPASS(1'b1)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .id_inst_i    (inst),
    .br_taken_i   (br),
    .pc_en_o      (pc_en),
    .ifid_en_o    (ifid_en),
    .ifid_flush_o (ifid_flush),
    .idex_flush_o (idex_flush),
    .stall_o      (stall)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
`endif
  );

  task automatic add_v(input string n, input logic r, input logic [31:0] in,
                       input logic b, input bit c, input logic [3:0] e);
    vec_t v;
    v.name = n; v.rst_n = r; v.inst = in; v.br = b; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic add_nops(input string n, input int cnt);
    for (int k = 0; k < cnt; k++) add_v(n, 1'b1, NOP, 1'b0, 1'b1, RUN);
  endtask

  task automatic check4(input string n, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {stall,pc_en,ifid_fl,idex_fl}=%b expected %b", n, act, exp);
    end
  endtask

  task automatic check32(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  initial begin
    // reset with an undriven instruction in ID
    add_v("rst_x_a", 1'b0, 'x, 1'b0, 1'b0, RUN);
    add_v("rst_x_b", 1'b0, 'x, 1'b0, 1'b0, RUN);
    add_v("reset_state", 1'b1, NOP, 1'b0, 1'b1, RUN);
    add_nops("nop_idle", 10);
    // back-to-back dependency: two stall cycles
    add_v("b2b_addi",   1'b1, ADDI5, 1'b0, 1'b1, RUN);
    add_v("b2b_stall1", 1'b1, ADD6,  1'b0, 1'b1, STL);
    add_v("b2b_stall2", 1'b1, ADD6,  1'b0, 1'b1, STL);
    add_v("b2b_issue",  1'b1, ADD6,  1'b0, 1'b1, RUN);
    add_nops("drain1", 3);
    // distance 2: one stall cycle
    add_v("d2_addi",  1'b1, ADDI5, 1'b0, 1'b1, RUN);
    add_v("d2_nop",   1'b1, NOP,   1'b0, 1'b1, RUN);
    add_v("d2_stall", 1'b1, ADD6,  1'b0, 1'b1, STL);
    add_v("d2_issue", 1'b1, ADD6,  1'b0, 1'b1, RUN);
    add_nops("drain2", 3);
    // distance 3: producer in WB, bypassed
    add_v("d3_addi",  1'b1, ADDI5, 1'b0, 1'b1, RUN);
    add_nops("d3_nop", 2);
    add_v("d3_issue", 1'b1, ADD6,  1'b0, 1'b1, RUN);
    add_nops("drain3", 3);
    // x0 never hazards
    add_v("x0_addi", 1'b1, ADDI0,  1'b0, 1'b1, RUN);
    add_v("x0_add",  1'b1, ADD600, 1'b0, 1'b1, RUN);
    add_nops("drain4", 1);
    // store writes no register; branch reads rs2
    add_v("st_sw",      1'b1, SW52,  1'b0, 1'b1, RUN);
    add_v("st_lw",      1'b1, LW75,  1'b0, 1'b1, RUN);
    add_nops("st_nop", 1);
    add_v("beq_addi",   1'b1, ADDI6, 1'b0, 1'b1, RUN);
    add_v("beq_stall1", 1'b1, BEQ56, 1'b0, 1'b1, STL);
    add_v("beq_stall2", 1'b1, BEQ56, 1'b0, 1'b1, STL);
    add_v("beq_issue",  1'b1, BEQ56, 1'b0, 1'b1, RUN);
    add_nops("drain5", 3);
    // redirect during a stall: redirect wins
    add_v("br_addi",   1'b1, ADDI5, 1'b0, 1'b1, RUN);
    add_v("br_stall",  1'b1, ADD6,  1'b0, 1'b1, STL);
    add_v("br_win",    1'b1, ADD6,  1'b1, 1'b1, BRF);
    add_v("br_after",  1'b1, NOP,   1'b0, 1'b1, RUN);
    add_v("br_nohaz",  1'b1, NOP,   1'b1, 1'b1, BRF);
    add_nops("drain6", 3);
    // reset during the second stall cycle
    add_v("rs_addi",    1'b1, ADDI5, 1'b0, 1'b1, RUN);
    add_v("rs_stall1",  1'b1, ADD6,  1'b0, 1'b1, STL);
    add_v("rs_stall2",  1'b0, ADD6,  1'b0, 1'b1, STL);
    add_v("rs_release", 1'b1, ADD6,  1'b0, 1'b1, RUN);
    add_v("rs_sb_empty",1'b1, ADD6,  1'b0, 1'b1, RUN);
    add_nops("tail", 2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst_n;
      inst  = vecs[i].inst;
      br    = vecs[i].br;
      @(negedge clk);
      if (vecs[i].chk) begin
        check4(vecs[i].name, {stall, pc_en, ifid_flush, idex_flush}, vecs[i].exp);
        total++;
        if (ifid_en !== pc_en) begin
          bad++;
          $display("FAIL %s_ifid_en: got %b expected %b", vecs[i].name, ifid_en, vecs[i].exp[2]);
        end
      end
`ifdef HAZARD_PERF_CNT_EN
      if (vecs[i].name == "rs_release") begin
        check32("stall_cnt_after_rst", stall_cnt, 32'd0);
        check32("flush_cnt_after_rst", flush_cnt, 32'd0);
      end
      if (i > 1) begin
        check32({vecs[i].name, "_stall_cnt"}, stall_cnt, m_stall);
        check32({vecs[i].name, "_flush_cnt"}, flush_cnt, m_flush);
      end
      // model the counter update at the coming edge
      if (!vecs[i].rst_n) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (vecs[i].exp[3]) m_stall++;
        if (vecs[i].br)     m_flush++;
      end
`endif
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
